// File: rtl/shift_sequencer.sv
// Serial shift/rotate unit: moves the operand one bit position per clock and
// produces results bit-identical to the single-cycle combinational shifter.
module shift_sequencer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [CNT_W-1:0]  count_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] res_o,
    output logic              cout_o
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] work, work_nxt;
    logic              cout, cout_nxt;
    logic [1:0]        op, op_nxt;
    logic [CNT_W-1:0]  remaining, remaining_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            work      <= '0;
            cout      <= 1'b0;
            op        <= 2'b00;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            work      <= work_nxt;
            cout      <= cout_nxt;
            op        <= op_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        work_nxt      = work;
        cout_nxt      = cout;
        op_nxt        = op;
        remaining_nxt = remaining;
        case (state)
            IDLE, DONE: begin
                // DONE accepts a new request directly so back-to-back ops need no bubble
                if (start_i) begin
                    work_nxt      = rs_i;
                    op_nxt        = ALUOp_i;
                    cout_nxt      = 1'b0;
                    remaining_nxt = count_i;
                    state_nxt     = (count_i != '0) ? SHIFT : DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                case (op)
                    2'b00: {cout_nxt, work_nxt} = {work, 1'b0};
                    2'b01: {work_nxt, cout_nxt} = {1'b0, work};
                    2'b10: begin
                        work_nxt = {work[DATA_W-2:0], work[DATA_W-1]};
                        cout_nxt = 1'b0;
                    end
                    default: begin
                        work_nxt = {work[0], work[DATA_W-1:1]};
                        cout_nxt = 1'b0;
                    end
                endcase
                remaining_nxt = remaining - CNT_W'(1);
                if (remaining == CNT_W'(1))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o = (state == SHIFT);
    assign done_o = (state == DONE);
    assign res_o  = work;
    assign cout_o = cout;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: a driver issues directed and random
// operations, a negedge monitor checks every done pulse against an arithmetic model.
module tb_shift_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] rs_i = 8'h00;
    logic [1:0] ALUOp_i = 2'b00;
    logic [2:0] count_i = 3'd0;
    logic       busy_o, done_o, cout_o;
    logic [7:0] res_o;

    shift_sequencer dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .rs_i    (rs_i),
        .ALUOp_i (ALUOp_i),
        .count_i (count_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .res_o   (res_o),
        .cout_o  (cout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] res;
        logic       cout;
        int         cnt;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   busy_run = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // Net effect of n single-bit steps, from plain integer arithmetic
    function automatic void model(input logic [7:0] rs, input logic [1:0] op, input int n,
                                  output logic [7:0] res, output logic cout);
        int v;
        v = rs;
        cout = 1'b0;
        case (op)
            2'b00: begin
                res = 8'((v << n) & 255);
                if (n > 0) cout = 1'((v >> (8 - n)) & 1);
            end
            2'b01: begin
                res = 8'(v >> n);
                if (n > 0) cout = 1'((v >> (n - 1)) & 1);
            end
            2'b10: res = 8'(((v << n) | (v >> (8 - n))) & 255);
            default: res = 8'(((v >> n) | (v << (8 - n))) & 255);
        endcase
    endfunction

    // Called at a negedge while the DUT is not busy; returns 1 ns after the accept edge
    task automatic issue(input logic [7:0] rs, input logic [1:0] op, input int n);
        exp_t e;
        model(rs, op, n, e.res, e.cout);
        e.cnt = n;
        e.acc_cyc = cyc;
        sb.push_back(e);
        start_i = 1'b1;
        rs_i = rs;
        ALUOp_i = op;
        count_i = 3'(n);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        rs_i = 8'($urandom);
        ALUOp_i = 2'($urandom);
        count_i = 3'($urandom);
    endtask

    // Returns at the negedge where done_o is seen; with noise, start_i is
    // toggled with junk while busy to show it is ignored
    task automatic wait_done(input bit noise);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
                start_i = 1'b0;
            end else if (noise && busy_o) begin
                start_i = 1'($urandom);
                rs_i = 8'($urandom);
                ALUOp_i = 2'($urandom);
                count_i = 3'($urandom);
            end else begin
                start_i = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            $display("FAIL done_timeout: got no done_o within 20 cycles, required a done pulse");
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            busy_run = 0;
        end else begin
            if (busy_o) busy_run++;
            if (done_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done_o=1 with no operation outstanding, required 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res", 32'(res_o), 32'(e.res));
                    chk("cout", 32'(cout_o), 32'(e.cout));
                    chk("latency", 32'(cyc - e.acc_cyc), 32'(e.cnt + 1));
                    chk("busy_cycles", 32'(busy_run), 32'(e.cnt));
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        #1 rst_i = 1'b1;
        #2;
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_res", 32'(res_o), 32'(0));
        chk("rst_cout", 32'(cout_o), 32'(0));
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        issue(8'hA5, 2'b00, 3); wait_done(0);
        issue(8'hA5, 2'b01, 1); wait_done(0);
        issue(8'h81, 2'b10, 4); wait_done(0);
        issue(8'h01, 2'b11, 7); wait_done(0);
        @(negedge clk_i);
        issue(8'h3C, 2'b00, 0); wait_done(0);

        // Start while busy: the 0x0F request must leave the in-flight op alone
        @(negedge clk_i);
        issue(8'hF0, 2'b00, 5);
        @(negedge clk_i);
        start_i = 1'b1; rs_i = 8'h0F; ALUOp_i = 2'b00; count_i = 3'd1;
        @(posedge clk_i); #1 start_i = 1'b0;
        wait_done(0);

        // Back-to-back: new op issued in the DONE cycle
        @(negedge clk_i);
        issue(8'h12, 2'b00, 2); wait_done(0);
        issue(8'h80, 2'b01, 7); wait_done(0);

        // Reset in the middle of a count-7 op
        @(negedge clk_i);
        issue(8'hFF, 2'b00, 7);
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'(0));
        chk("midrst_done", 32'(done_o), 32'(0));
        chk("midrst_res", 32'(res_o), 32'(0));
        chk("midrst_cout", 32'(cout_o), 32'(0));
        sb.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);
        issue(8'h5A, 2'b11, 2); wait_done(0);

        // Random ops, random gaps (0 = back-to-back), junk starts while busy
        for (int k = 0; k < 200; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk_i);
            issue(8'($urandom), 2'($urandom), int'($urandom_range(0, 7)));
            wait_done(1);
        end

        repeat (3) @(negedge clk_i);
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle serial shift/rotate unit for the Gumnut datapath.
- Accepts one 8-bit operand, a shift opcode and a 3-bit count, then shifts one bit position per clock.
- Presents the result and carry-out with a one-cycle done pulse.
- Results are bit-identical to the core's combinational shifter; used where area matters more than latency and the pipeline stalls on busy_o.

Parameters:
- DATA_W, 8, operand/result width; only 8 is supported.
- CNT_W, 3, count width; must equal log2(DATA_W).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  request; sampled only when busy_o=0.
- rs_i  input  8  operand.
- ALUOp_i  input  2  00 shl logical, 01 shr logical, 10 rol, 11 ror.
- count_i  input  3  shift amount 0..7.
- busy_o  output  1  high while an operation is in progress.
- done_o  output  1  one-cycle pulse when res_o/cout_o become valid.
- res_o  output  8  result; holds its value until the next accepted start.
- cout_o  output  1  carry out; holds its value until the next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE; busy_o=0, done_o=0, res_o=8'h00, cout_o=0; internal counter=0, opcode register=0.
- States: IDLE, SHIFT, DONE.
- Accept (IDLE or DONE, start_i=1, at a clock edge):
  - capture rs_i into the working register; capture ALUOp_i and count_i; clear cout_o to 0.
  - count_i≠0 → go to SHIFT with remaining=count_i.
  - count_i=0 → go directly to DONE.
- SHIFT, each edge: perform one step, then decrement remaining. When remaining reaches 1 before the step, go to DONE after that step.
- Single step, working register r:
  - shl: cout←r[7], r←{r[6:0],0}.
  - shr: cout←r[0], r←{0,r[7:1]}.
  - rol: r←{r[6:0],r[7]}, cout←0.
  - ror: r←{r[0],r[7:1]}, cout←0.
- Net result after N steps:
  - shl/shr: cout = last bit shifted out.
  - rotates: cout = 0.
  - count 0: res=rs_i, cout=0.
- DONE: done_o=1 for exactly this one cycle. Next state is IDLE, or a new accept if start_i=1 (back-to-back, no bubble).
- busy_o=1 in SHIFT only. busy_o=0 in IDLE and DONE.
- res_o is driven directly from the working register.
  - During SHIFT, res_o shows intermediate values; consumers must qualify them with done_o.
  - From done_o onward, res_o and cout_o hold stable until the next accept.
- Latency: accept edge to done_o high = count+1 cycles. Throughput: one operation per count+1 cycles.
- start_i while busy_o=1: ignored; no queuing, and in-flight state is unchanged. rs_i, ALUOp_i and count_i may change freely after the accept edge.
- Reset asserted mid-SHIFT: operation aborted; no done_o pulse; all outputs return to reset values immediately.
- Unknown (X) ALUOp_i at accept: the X propagates to res_o; no recovery required.

Test Plan:
- rst_i pulse mid-cycle → busy_o=0, done_o=0, res_o=0x00, cout_o=0 asynchronously; no done_o pulse afterwards.
- Shift left, logical: rs_i=0xA5, ALUOp_i=00, count_i=3, start_i one cycle.
  - Expect busy_o high for 3 cycles.
  - Expect done_o on the 4th cycle after accept, with res_o=0x28, cout_o=1.
- Shift right and rotate left:
  - rs_i=0xA5, ALUOp_i=01, count_i=1 → done_o 2 cycles after accept; res_o=0x52, cout_o=1.
  - rs_i=0x81, ALUOp_i=10, count_i=4 → res_o=0x18, cout_o=0.
- Rotate right and zero count:
  - rs_i=0x01, ALUOp_i=11, count_i=7 → res_o=0x02, cout_o=0, done_o 8 cycles after accept.
  - rs_i=0x3C, ALUOp_i=00, count_i=0 → done_o next cycle; res_o=0x3C, cout_o=0; busy_o never high.
- Start while busy: start 0xF0 shl 5, then pulse start_i with 0x0F during SHIFT.
  - The second request is ignored.
  - Result is res_o=0x00, cout_o=0 (last bit out is bit 3 of 0xF0).
- Back-to-back: hold start_i=1 in the DONE cycle with a new op (0x80 shr 7).
  - The new op is accepted without an IDLE cycle.
  - Second done_o gives res_o=0x01, cout_o=0.
- Reset mid-operation: assert rst_i during SHIFT of a count-7 op.
  - Outputs return to reset values and no done_o appears.
  - The next start executes normally.
